// File: rtl/shift_vector_writer_if.sv
// shift_vector_writer_if
//   Vector handshake between the vector multiplier result path (master)
//   and shift_vector_writer (slave).
//   vector_in    : VECTOR_DIMENSION elements, element 0 lands at the lowest address
//   vector_valid : vector_in holds a vector to be written
//   vector_ready : writer can take a vector this cycle
interface shift_vector_writer_if #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int VECTOR_DIMENSION = 3
);
  logic [ELEMENT_WIDTH-1:0] vector_in [0:VECTOR_DIMENSION-1];
  logic                     vector_valid;
  logic                     vector_ready;

  modport master (output vector_in, output vector_valid, input vector_ready);
  modport slave  (input vector_in, input vector_valid, output vector_ready);
endinterface

// File: rtl/shift_vector_writer.sv
// shift_vector_writer
//   Serializes whole vectors into a single-port element RAM, one element per
//   clock, at sequential addresses from 0. Stops and raises done once
//   expected_elements elements have been written.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   expected_elements  : total elements to write (stable between resets)
//   enabled            : high allows acceptance and writing, low stalls in place
//   vec                : vector handshake (slave side of shift_vector_writer_if)
//   we, addr, data_out : registered RAM write port
//   elements_written   : elements written since reset
//   done               : elements_written == expected_elements
//   checksum           : running XOR of written data (only with
//                        SHIFT_VECTOR_WRITER_CHECKSUM_EN defined)
//
// Optional feature macro: SHIFT_VECTOR_WRITER_CHECKSUM_EN
//
// state | meaning
// IDLE  | waiting for a vector; we held low
// WRITE | emitting buffer[count] once per enabled cycle
module shift_vector_writer #(
  parameter int ELEMENT_WIDTH    = 24,
  parameter int ADDR_WIDTH       = 17,
  parameter int VECTOR_DIMENSION = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ELEMENT_WIDTH-1:0] expected_elements,
  input  logic                     enabled,
  shift_vector_writer_if.slave     vec,
  output logic                     we,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic [ELEMENT_WIDTH-1:0] data_out,
  output logic [ELEMENT_WIDTH-1:0] elements_written,
  output logic                     done
`ifdef SHIFT_VECTOR_WRITER_CHECKSUM_EN
  ,
  output logic [ELEMENT_WIDTH-1:0] checksum
`endif
);

  localparam int CW = $clog2(VECTOR_DIMENSION);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                   state;
  logic [ELEMENT_WIDTH-1:0] buffer [0:VECTOR_DIMENSION-1];
  logic [CW-1:0]            count;
  logic [ADDR_WIDTH-1:0]    wr_ptr;
  logic                     last_write;
  logic                     last_elem;

  assign done             = (elements_written == expected_elements);
  assign vec.vector_ready = (state == IDLE) && enabled && !done;
  // The write issued this cycle is the final one overall.
  assign last_write       = (elements_written == expected_elements - ELEMENT_WIDTH'(1));
  assign last_elem        = (count == CW'(VECTOR_DIMENSION - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      we               <= 1'b0;
      addr             <= '0;
      data_out         <= '0;
      elements_written <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      for (int i = 0; i < VECTOR_DIMENSION; i++) buffer[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          we <= 1'b0;
          if (vec.vector_valid && vec.vector_ready) begin
            for (int i = 0; i < VECTOR_DIMENSION; i++) buffer[i] <= vec.vector_in[i];
            count <= '0;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (enabled) begin
            we               <= 1'b1;
            addr             <= wr_ptr;
            data_out         <= buffer[count];
            elements_written <= elements_written + ELEMENT_WIDTH'(1);
            // Pointer wraps after the final write so a rerun starts at 0.
            wr_ptr           <= last_write ? '0 : wr_ptr + ADDR_WIDTH'(1);
            // A truncated final vector leaves the rest of the buffer unwritten.
            if (last_elem || last_write) begin
              count <= '0;
              state <= IDLE;
            end else begin
              count <= count + CW'(1);
            end
          end else begin
            we <= 1'b0;
          end
        end
        default: begin
          we    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SHIFT_VECTOR_WRITER_CHECKSUM_EN
  // Folds in the element on the same edge it is driven onto data_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (state == WRITE && enabled) begin
      checksum <= checksum ^ buffer[count];
    end
  end
`endif

endmodule

// File: doc/shift_vector_writer.md
# shift_vector_writer

Serializes full vectors into a single-port element RAM, one element per clock, at sequential addresses starting at 0; every VECTOR_DIMENSION consecutive addresses hold one vector. It is the write-side counterpart of the vector constructor. It sits between the vector multiplier result path and the result RAM. It stops and raises `done` once `expected_elements` elements have been written.

## Interface
- `ELEMENT_WIDTH`, 24, bit width of one element (RAM data width)
- `ADDR_WIDTH`, 17, RAM address width
- `VECTOR_DIMENSION`, 3, elements per vector (≥2)
- `clk` input 1 clock; RAM write port uses the same clock
- `reset` input 1: reset reset, synchronous, active-high; clock clk
- `expected_elements` input ELEMENT_WIDTH: total elements to write; held stable between resets
- `enabled` input 1: high allows acceptance and writing; low stalls in place
- `vector_in` input ELEMENT_WIDTH x [0:VECTOR_DIMENSION-1]: vector to write; element 0 goes to the lowest address
- `vector_valid` input 1: `vector_in` is valid
- `vector_ready` output 1: block can accept a vector this cycle
- `we` output 1: RAM write enable (registered)
- `addr` output ADDR_WIDTH: RAM write address (registered)
- `data_out` output ELEMENT_WIDTH: RAM write data (registered)
- `elements_written` output ELEMENT_WIDTH: elements written since reset
- `done` output 1: all expected elements written

## Operation
- States: IDLE, WRITE. Internal regs: `buffer[0:VECTOR_DIMENSION-1]`, `count` ($clog2(VECTOR_DIMENSION) bits), `wr_ptr` (ADDR_WIDTH).
- `done` = (`elements_written` == `expected_elements`), combinational.
- `vector_ready` = (state==IDLE) && `enabled` && !`done`, combinational.
- IDLE: on `vector_valid && vector_ready`, latch `vector_in` into `buffer`, set `count`←0, go to WRITE. Otherwise hold. `we`←0.
- WRITE, `enabled` high:
  - `we`←1, `addr`←`wr_ptr`, `data_out`←`buffer[count]`.
  - `elements_written`←+1.
  - `wr_ptr`←0 if `elements_written` == `expected_elements`−1, else `wr_ptr`+1. Wrap is for a rerun after reset.
  - If `count` == VECTOR_DIMENSION−1, or this write reaches `expected_elements`: go to IDLE and set `count`←0. Otherwise `count`+1.
- WRITE, `enabled` low: `we`←0; all other state holds; resumes at the same element.
- `expected_elements` not a multiple of VECTOR_DIMENSION: the final vector is truncated. Remaining buffer elements are discarded.
- `expected_elements` = 0: `done` is high out of reset, `vector_ready` stays low, and no write occurs.
- After `done`: `vector_valid` is ignored (not accepted) and `we` stays 0 until reset.
- Width: `elements_written` compares at full ELEMENT_WIDTH; `wr_ptr` truncates to ADDR_WIDTH. Callers keep `expected_elements` ≤ 2^ADDR_WIDTH.

## Timing
- Reset (synchronous, takes effect at the edge):
  - state=IDLE; `we`=0, `addr`=0, `data_out`=0; `elements_written`=0; `wr_ptr`=0; `count`=0; buffer=0.
  - Hence `vector_ready`=`enabled` && (`expected_elements`≠0).
- Reset mid-WRITE: the buffered vector is abandoned. `we` is 0 after the reset edge.
- Vector accepted at edge k: writes of element i appear on `we/addr/data_out` after edge k+1+i. This assumes no stall.
- `vector_ready` reasserts after edge k+VECTOR_DIMENSION. Steady throughput is one vector per VECTOR_DIMENSION+1 cycles.
- `elements_written` updates on the same edge that drives the corresponding `we`. `done` rises on the edge of the final write.
- Each stalled cycle (`enabled` low) delays all later writes by one cycle. No element is skipped or duplicated.

## Configuration
- `SHIFT_VECTOR_WRITER_CHECKSUM_EN` defined:
  - Adds output `checksum` [ELEMENT_WIDTH-1:0], the running XOR of every `data_out` written with `we`=1.
  - Reset value 0. It updates on the same edge as the write, so after the final write it equals the XOR of all written elements.
- Macro undefined: no `checksum` port or logic. All other behaviour is identical.

## Test plan
- Basic: ELEMENT_WIDTH=24, VECTOR_DIMENSION=3, expected=6; offer {1,2,3} then {4,5,6} with valid held high.
  - Writes (addr,data) = (0,1)(1,2)(2,3)(3,4)(4,5)(5,6). `we` is low for one cycle between vectors.
  - `done` rises with the (5,6) write, and `vector_ready` stays low afterwards.
- Stall: expected=3; drop `enabled` for 2 cycles after the first write of {7,8,9}.
  - Writes are exactly (0,7)(1,8)(2,9) with a 2-cycle gap, no duplicates, and `elements_written`=3.
- Truncation: expected=4, vectors {1,2,3},{4,5,6}.
  - Writes (0,1)…(3,4) only; `done`=1; the second vector's 5 and 6 are never written.
- Zero/after done: expected=0.
  - `done`=1 and `vector_ready`=0 after reset; a valid vector produces no `we`.
- Reset mid-write: assert `reset` after the second element of {10,11,12}.
  - `we`=0 next cycle, `elements_written`=0, `addr`=0. Rerunning with expected=3 restarts at addr 0.
- Checksum (macro defined): write {0x0F,0xF0,0x01}; `checksum`=0xFE after the last write.
